remote_cmd_tx: RTL and testbench
================================

# remote_cmd_tx

Transmitting end of the robot's 16-bit command link: accepts a 16-bit command word from a host-side sequencer or testbench and serializes it as two 8N1 UART frames, high byte first. The frames are what the robot's UART receive wrapper reassembles into `cmd`/`cmd_rdy`. The block contains its own baud generator, shift register and two-byte sequencer. It also serves as the command driver for full-chip simulation.

## Interface
Parameters:
- BAUD_DIV, default 2604 — clk cycles per bit (50 MHz / 19200 baud); legal range 2..4095.

Ports:
- clk  input  1  operational clock
- rst_n  input  1  reset: asynchronous, active-low
- cmd  input  16  command word; sampled only on an accepted snd_cmd
- snd_cmd  input  1  single-cycle request to send cmd
- TX  output  1  serial line; idles high
- busy  output  1  high while a transfer is in progress
- cmd_snt  output  1  high once both bytes have left the line; held until the next accepted snd_cmd

## Operation
- Reset values:
  - TX = 1, busy = 0, cmd_snt = 0.
  - Sequencer in IDLE; baud counter and bit counter at 0.
- Capture:
  - snd_cmd is accepted only when busy = 0.
  - On an accepted request, cmd[7:0] is latched into a holding register, cmd[15:8] is loaded into the shifter, cmd_snt clears and busy sets.
  - snd_cmd while busy = 1 is ignored; in-flight data is unaffected.
- Frame format:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Every bit is held on TX for exactly BAUD_DIV cycles.
- Sequencer states and transitions:
  - IDLE → HIGH on an accepted snd_cmd.
  - HIGH: transmits the high byte. At the end of its stop bit → LOW, loading the held low byte (→ GAP when the gap option is built in).
  - GAP: TX held at 1 for BAUD_DIV cycles, then → LOW.
  - LOW: transmits the low byte. At the end of its stop bit → IDLE, with busy cleared and cmd_snt set in the same edge.
- Counters:
  - Baud counter is 12 bits; it counts 0..BAUD_DIV-1 and its wrap advances the bit.
  - Bit counter is 4 bits; it counts 0..9 per frame.
  - Both counters clear on load.
- TX is driven directly from a flop; it is not combinational.
- Simultaneous events:
  - snd_cmd in the cycle cmd_snt is high and busy is low is accepted: cmd_snt clears and the new transfer starts.
  - snd_cmd in the final cycle of the low-byte stop bit (busy still 1) is ignored.
- Reset asserted mid-frame: all state clears immediately, and TX returns to 1 asynchronously.

## Timing
- Latency: snd_cmd high at rising edge N → TX = 0 (start bit) from edge N+1.
- No gap: the high-byte start bit occupies cycles N+1 .. N+BAUD_DIV. The low-byte start bit follows the high-byte stop bit with zero idle cycles.
- Total line time is 20·BAUD_DIV cycles.
- cmd_snt and busy = 0 both take effect at edge N+1+20·BAUD_DIV.
- The earliest next accepted snd_cmd is at that same edge.
- cmd_snt is a level, not a pulse.

## Configuration
- CMD_TX_IFG_EN:
  - Defined: the GAP state is compiled in, inserting one bit-time (BAUD_DIV cycles) of idle-high between the two frames. Total transfer time becomes 21·BAUD_DIV cycles, and cmd_snt is set at edge N+1+21·BAUD_DIV.
  - Undefined: no GAP state, back-to-back frames, 20·BAUD_DIV cycles.

## Test plan
All scenarios use BAUD_DIV = 16.
- Reset then idle 100 cycles → TX = 1, busy = 0, cmd_snt = 0 throughout.
- cmd = 16'hA5C3 with one snd_cmd pulse → TX shows, LSB first, each bit for 16 cycles:
  - high frame 0,1,0,1,0,0,1,0,1,1;
  - low frame 0,1,1,0,0,0,0,1,1,1.
  - cmd_snt rises exactly 321 cycles after the snd_cmd edge.
- snd_cmd with cmd = 16'h0003, then snd_cmd with cmd = 16'hFFFF pulsed at cycle 50 → second request ignored; line carries 0x00 then 0x03 only.
- Re-issue snd_cmd in the cycle cmd_snt first goes high, with cmd = 16'h1234 → cmd_snt drops next cycle and TX start bit begins at the next edge; frames 0x12 then 0x34.
- Assert rst_n low at cycle 80 of a transfer → TX = 1 and busy = 0 immediately. A subsequent send of 16'h00FF completes cleanly.
- Build with CMD_TX_IFG_EN, send 16'h8001 → TX high for 16 cycles between frames; cmd_snt at 337 cycles.

Source files
------------

// File: rtl/remote_cmd_tx.sv
// 16-bit command transmitter: two 8N1 UART frames, high byte first.
// Optional CMD_TX_IFG_EN inserts one idle-high bit time between the frames.
module remote_cmd_tx #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_snt
);

`ifdef CMD_TX_IFG_EN
    typedef enum logic [1:0] {IDLE, HIGH, GAP, LOW} state_t;
`else
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
`endif

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

    state_t      state;
    logic [11:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shifter;
    logic [7:0]  hold;
    logic        baud_wrap;

    assign baud_wrap = (baud_cnt == BAUD_LAST);

    // TX is updated on the same edge the counters wrap, so each bit appears on
    // the line for exactly BAUD_DIV cycles, starting the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= '0;
            hold     <= '0;
            TX       <= 1'b1;
            busy     <= 1'b0;
            cmd_snt  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (snd_cmd) begin
                        shifter  <= cmd[15:8];
                        hold     <= cmd[7:0];
                        TX       <= 1'b0;
                        busy     <= 1'b1;
                        cmd_snt  <= 1'b0;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= HIGH;
                    end
                end
                HIGH, LOW: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            bit_cnt <= '0;
                            if (state == HIGH) begin
`ifdef CMD_TX_IFG_EN
                                TX    <= 1'b1;
                                state <= GAP;
`else
                                TX      <= 1'b0;
                                shifter <= hold;
                                state   <= LOW;
`endif
                            end else begin
                                TX      <= 1'b1;
                                busy    <= 1'b0;
                                cmd_snt <= 1'b1;
                                state   <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            TX      <= (bit_cnt == 4'd8) ? 1'b1 : shifter[0];
                            shifter <= {1'b0, shifter[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
`ifdef CMD_TX_IFG_EN
                GAP: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        TX       <= 1'b0;
                        shifter  <= hold;
                        state    <= LOW;
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_remote_cmd_tx.sv
// Self-checking bench for remote_cmd_tx (BAUD_DIV = 16); a line monitor decodes
// frames and compares each byte against a scoreboard queue filled at send time.
module tb_remote_cmd_tx;

    localparam int unsigned BD = 16;
`ifdef CMD_TX_IFG_EN
    localparam int LAT = 21 * 16 + 1;
`else
    localparam int LAT = 20 * 16 + 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd = '0;
    logic        snd_cmd = 1'b0;
    logic        TX;
    logic        busy;
    logic        cmd_snt;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic mon_en = 1'b1;

    remote_cmd_tx #(.BAUD_DIV(BD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (cmd),
        .snd_cmd (snd_cmd),
        .TX      (TX),
        .busy    (busy),
        .cmd_snt (cmd_snt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line monitor: sample mid-bit, compare decoded bytes with the scoreboard.
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && TX === 1'b0) begin
                repeat (8) @(negedge clk);
                n_cmp++;
                if (TX !== 1'b0) begin
                    n_err++;
                    $display("FAIL start_bit got=%b expected=0", TX);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BD) @(negedge clk);
                n_cmp++;
                if (TX !== 1'b1) begin
                    n_err++;
                    $display("FAIL stop_bit got=%b expected=1", TX);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL frame_unexpected got=%h expected=none", b);
                end else begin
                    e = exp_q.pop_front();
                    if (b !== e) begin
                        n_err++;
                        $display("FAIL frame_byte got=%h expected=%h", b, e);
                    end
                end
            end
        end
    end

    // Leaves the bench 1 ns after the edge that samples snd_cmd.
    task automatic pulse(input logic [15:0] c);
        @(posedge clk); #1;
        cmd = c;
        snd_cmd = 1'b1;
        @(posedge clk); #1;
        snd_cmd = 1'b0;
    endtask

    task automatic wait_snt(inout int lat);
        while (cmd_snt !== 1'b1 && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({TX, busy, cmd_snt} !== 3'b100) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got=%b expected=100", i, {TX, busy, cmd_snt});
            end
        end
    endtask

    task automatic test_basic;
        int lat = 1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hC3);
        pulse(16'hA5C3);
        n_cmp++;
        if ({TX, busy, cmd_snt} !== 3'b010) begin
            n_err++;
            $display("FAIL basic_start got=%b expected=010", {TX, busy, cmd_snt});
        end
        wait_snt(lat);
        n_cmp++;
        if (lat != LAT) begin
            n_err++;
            $display("FAIL basic_latency got=%0d expected=%0d", lat, LAT);
        end
        n_cmp++;
        if ({TX, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL basic_done got=%b expected=10", {TX, busy});
        end
    endtask

    task automatic test_ignore_busy;
        int lat = 1;
        logic bad = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h03);
        pulse(16'h0003);
        repeat (49) begin
            @(posedge clk); #1;
            lat++;
        end
        cmd = 16'hFFFF;
        snd_cmd = 1'b1;
        @(posedge clk); #1;
        lat++;
        snd_cmd = 1'b0;
        wait_snt(lat);
        n_cmp++;
        if (lat != LAT) begin
            n_err++;
            $display("FAIL ignore_latency got=%0d expected=%0d", lat, LAT);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_quiet got=%b expected=0", bad);
        end
    endtask

    task automatic test_back_to_back;
        int lat = 1;
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'h0F);
        pulse(16'h0F0F);
        wait_snt(lat);
        n_cmp++;
        if (lat != LAT) begin
            n_err++;
            $display("FAIL b2b_first_latency got=%0d expected=%0d", lat, LAT);
        end
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        cmd = 16'h1234;
        snd_cmd = 1'b1;
        @(posedge clk); #1;
        snd_cmd = 1'b0;
        n_cmp++;
        if ({TX, busy, cmd_snt} !== 3'b010) begin
            n_err++;
            $display("FAIL b2b_restart got=%b expected=010", {TX, busy, cmd_snt});
        end
        lat = 1;
        wait_snt(lat);
        n_cmp++;
        if (lat != LAT) begin
            n_err++;
            $display("FAIL b2b_second_latency got=%0d expected=%0d", lat, LAT);
        end
    endtask

    task automatic test_reset_mid;
        int lat = 1;
        mon_en = 1'b0;
        pulse(16'h0000);
        repeat (79) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (TX !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_pre got=%b expected=0", TX);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({TX, busy, cmd_snt} !== 3'b100) begin
            n_err++;
            $display("FAIL midreset_async got=%b expected=100", {TX, busy, cmd_snt});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (200) @(posedge clk);
        mon_en = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        pulse(16'h00FF);
        lat = 1;
        wait_snt(lat);
        n_cmp++;
        if (lat != LAT) begin
            n_err++;
            $display("FAIL midreset_resend_latency got=%0d expected=%0d", lat, LAT);
        end
    endtask

`ifdef CMD_TX_IFG_EN
    task automatic test_gap;
        int lat = 1;
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h01);
        pulse(16'h8001);
        while (lat < 177) begin
            @(posedge clk); #1;
            lat++;
            if (lat >= 161 && lat <= 176) begin
                n_cmp++;
                if (TX !== 1'b1) begin
                    n_err++;
                    $display("FAIL gap_idle k=%0d got=%b expected=1", lat, TX);
                end
            end
        end
        n_cmp++;
        if (TX !== 1'b0) begin
            n_err++;
            $display("FAIL gap_low_start got=%b expected=0", TX);
        end
        wait_snt(lat);
        n_cmp++;
        if (lat != 337) begin
            n_err++;
            $display("FAIL gap_latency got=%0d expected=337", lat);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid;
`ifdef CMD_TX_IFG_EN
        test_gap;
`endif
        repeat (50) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL frames_missing got=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
